// File: rtl/expansion_pin_tester.sv
// expansion_pin_tester: bring-up driver for the expansion connector pins.
// Manual, walking-one, toggle and bus loopback modes behind 2-flop synchronisers.
module expansion_pin_tester #(
    parameter int PINS         = 8,
    parameter int GROUPS       = 3,
    parameter int BUS_GROUP    = 1,
    parameter int DWELL_CYCLES = 100000000,
    parameter int PWM_BITS     = 3,
    localparam int GW = $clog2(GROUPS),
    localparam int PW = $clog2(PINS),
    localparam int NW = GROUPS * PINS,
    localparam int SW = $clog2(NW),
    localparam int DW = $clog2(DWELL_CYCLES)
) (
    input  logic          i_clk100,
    input  logic          i_nreset,
    input  logic [1:0]    i_mode,
    input  logic [GW-1:0] i_group,
    input  logic [PW-1:0] i_pin,
    input  logic          i_level,
    input  logic          i_dirIn,
    input  logic [PINS-1:0] i_busIn,
    output logic [NW-1:0] o_drive,
    output logic [PINS-1:0] o_busOe,
    output logic          o_led,
    output logic          o_err,
    output logic [7:0]    o_errCount,
    output logic [SW-1:0] o_step
);

    typedef enum logic [1:0] {
        M_MANUAL = 2'b00,
        M_WALK   = 2'b01,
        M_TOGGLE = 2'b10,
        M_LOOP   = 2'b11
    } mode_t;

    localparam int SYW = 2 + GW + PW + 2 + PINS;

    logic [SYW-1:0]  r_sync1;
    logic [SYW-1:0]  r_sync2;
    logic [1:0]      w_modeRaw;
    mode_t           w_mode;
    logic [GW-1:0]   w_group;
    logic [PW-1:0]   w_pin;
    logic            w_level;
    logic            w_dirIn;
    logic [PINS-1:0] w_busIn;

    mode_t           r_mode;
    logic [DW-1:0]   r_dwell;
    logic [SW-1:0]   r_step;
    logic            r_tog;
    logic [1:0]      r_cmp;
    logic [PWM_BITS-1:0] r_pwm;
    logic [NW-1:0]   r_drive;
    logic [PINS-1:0] r_oe;
    logic            r_led;
    logic            r_err;
    logic [7:0]      r_errCount;

    logic            w_chg;
    logic            w_tick;
    logic            w_valid;
    logic            w_selBus;
    logic [SW-1:0]   w_sel;
    logic [DW-1:0]   w_dwellN;
    logic [SW-1:0]   w_stepN;
    logic            w_togN;
    logic [1:0]      w_cmpN;
    logic [NW-1:0]   w_driveN;
    logic [PINS-1:0] w_oeN;
    logic            w_errN;
    logic [7:0]      w_cntN;
    logic            w_src;

    assign {w_modeRaw, w_group, w_pin, w_level, w_dirIn, w_busIn} = r_sync2;
    assign w_mode   = mode_t'(w_modeRaw);
    assign w_valid  = (int'(w_group) < GROUPS) && (int'(w_pin) < PINS);
    assign w_selBus = w_valid && (int'(w_group) == BUS_GROUP);
    assign w_sel    = SW'(int'(w_group) * PINS + int'(w_pin));

    always_comb begin
        w_chg    = (w_mode != r_mode);
        w_tick   = (r_dwell == DW'(DWELL_CYCLES - 1));
        w_dwellN = w_tick ? '0 : r_dwell + DW'(1);
        w_stepN  = r_step;
        w_togN   = r_tog;
        // A mode change outranks a coincident tick.
        if (w_chg) begin
            w_dwellN = '0;
            w_stepN  = '0;
            w_togN   = 1'b0;
        end else if (w_tick) begin
            case (w_mode)
                M_WALK:   w_stepN = (r_step == SW'(NW - 1)) ? '0 : r_step + SW'(1);
                M_TOGGLE: w_togN  = ~r_tog;
                M_LOOP:   w_stepN = (r_step == SW'(PINS - 1)) ? '0 : r_step + SW'(1);
                default:  ;
            endcase
        end

        w_driveN = '0;
        w_oeN    = '0;
        case (w_mode)
            M_MANUAL: begin
                if (!w_dirIn && w_valid) begin
                    w_driveN[w_sel] = w_level;
                    w_oeN[w_pin]    = w_selBus;
                end
            end
            M_WALK: begin
                w_driveN[w_stepN] = 1'b1;
                w_oeN = w_driveN[BUS_GROUP*PINS +: PINS];
            end
            M_TOGGLE: begin
                if (w_valid) begin
                    w_driveN[w_sel] = w_togN;
                    w_oeN[w_pin]    = w_selBus;
                end
            end
            default: begin
                w_driveN[BUS_GROUP*PINS +: PINS] = PINS'(1) << w_stepN;
                w_oeN = '1;
            end
        endcase

        // Compare once the new pattern has crossed the readback synchroniser.
        w_cmpN = (r_cmp != 2'd0) ? r_cmp - 2'd1 : 2'd0;
        w_errN = r_err;
        w_cntN = r_errCount;
        if (w_chg) begin
            w_errN = 1'b0;
            w_cntN = '0;
        end else if (w_mode == M_LOOP && r_cmp == 2'd1 &&
                     w_busIn != r_drive[BUS_GROUP*PINS +: PINS]) begin
            w_errN = 1'b1;
            if (r_errCount != 8'hFF) w_cntN = r_errCount + 8'd1;
        end
        if (w_mode == M_LOOP && (w_chg || w_tick)) w_cmpN = 2'd3;
        else if (w_chg) w_cmpN = 2'd0;

        w_src = 1'b0;
        case (w_mode)
            M_MANUAL: w_src = w_dirIn ? (w_valid & w_busIn[w_pin]) : w_level;
            M_WALK,
            M_TOGGLE: w_src = w_valid & w_driveN[w_sel];
            default:  w_src = w_errN;
        endcase
    end

    always_ff @(posedge i_clk100 or negedge i_nreset) begin
        if (!i_nreset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_mode     <= M_MANUAL;
            r_dwell    <= '0;
            r_step     <= '0;
            r_tog      <= 1'b0;
            r_cmp      <= '0;
            r_pwm      <= '0;
            r_drive    <= '0;
            r_oe       <= '0;
            r_led      <= 1'b0;
            r_err      <= 1'b0;
            r_errCount <= '0;
        end else begin
            r_sync1    <= {i_mode, i_group, i_pin, i_level, i_dirIn, i_busIn};
            r_sync2    <= r_sync1;
            r_mode     <= w_mode;
            r_dwell    <= w_dwellN;
            r_step     <= w_stepN;
            r_tog      <= w_togN;
            r_cmp      <= w_cmpN;
            r_pwm      <= r_pwm + PWM_BITS'(1);
            r_drive    <= w_driveN;
            r_oe       <= w_oeN;
            r_led      <= ~r_pwm[PWM_BITS-1] & w_src;
            r_err      <= w_errN;
            r_errCount <= w_cntN;
        end
    end

    assign o_drive    = r_drive;
    assign o_busOe    = r_oe;
    assign o_led      = r_led;
    assign o_err      = r_err;
    assign o_errCount = r_errCount;
    assign o_step     = r_step;

endmodule

// File: tb/tb_expansion_pin_tester.sv
// Scoreboard bench for expansion_pin_tester: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_expansion_pin_tester;

    localparam int S_DRV  = 0;
    localparam int S_OE   = 1;
    localparam int S_LED  = 2;
    localparam int S_ERR  = 3;
    localparam int S_CNT  = 4;
    localparam int S_STEP = 5;
    localparam int S_LEDN = 6;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [1:0]  mode = '0;
    logic [1:0]  group = '0;
    logic [2:0]  pin = '0;
    logic        level = 1'b0;
    logic        dirIn = 1'b0;
    logic [7:0]  busMan = '0;
    logic [7:0]  busIn;
    logic [23:0] drive;
    logic [7:0]  oe;
    logic        led;
    logic        err;
    logic [7:0]  errCount;
    logic [4:0]  step;
    int          busSel = 0;

    int cyc = 0;
    int nTests = 0;
    int nFail = 0;
    logic [7:0]  hist = '0;
    logic [31:0] act;

    typedef struct {
        int          c;
        int          sig;
        logic [31:0] v;
    } exp_t;
    exp_t q[$];

    expansion_pin_tester #(
        .PINS(8), .GROUPS(3), .BUS_GROUP(1), .DWELL_CYCLES(4), .PWM_BITS(3)
    ) dut (
        .i_clk100(clk), .i_nreset(nreset), .i_mode(mode), .i_group(group),
        .i_pin(pin), .i_level(level), .i_dirIn(dirIn), .i_busIn(busIn),
        .o_drive(drive), .o_busOe(oe), .o_led(led), .o_err(err),
        .o_errCount(errCount), .o_step(step)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Loopback wiring: 0 = bench value, 1 = ideal tie, 2 = bus bit 3 stuck low.
    assign busIn = (busSel == 1) ? drive[15:8] :
                   (busSel == 2) ? (drive[15:8] & 8'hF7) : busMan;

    function automatic string sname(int s);
        case (s)
            S_DRV:  return "drive";
            S_OE:   return "busOe";
            S_LED:  return "led";
            S_ERR:  return "err";
            S_CNT:  return "errCount";
            S_STEP: return "step";
            default: return "ledHighOf8";
        endcase
    endfunction

    function automatic logic [31:0] actual(int s);
        case (s)
            S_DRV:  return {8'h0, drive};
            S_OE:   return {24'h0, oe};
            S_LED:  return {31'h0, led};
            S_ERR:  return {31'h0, err};
            S_CNT:  return {24'h0, errCount};
            S_STEP: return {27'h0, step};
            default: return 32'($countones(hist));
        endcase
    endfunction

    function automatic void expect_at(int c, int s, logic [31:0] v);
        q.push_back('{c, s, v});
    endfunction

    always @(negedge clk) begin
        hist = {hist[6:0], led};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].c <= cyc) begin
                act = actual(q[i].sig);
                nTests++;
                if (q[i].c < cyc || act !== q[i].v) begin
                    nFail++;
                    $display("FAIL %s @cyc %0d: got %0h, expected %0h",
                             sname(q[i].sig), q[i].c, act, q[i].v);
                end
                q.delete(i);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input logic [1:0] m, input logic [1:0] g,
                         input logic [2:0] p, input logic l, input logic d,
                         output int t);
        @(posedge clk);
        #1;
        mode = m; group = g; pin = p; level = l; dirIn = d;
        t = cyc;
    endtask

    initial begin
        int t, t2, tr, j;
        mode = 2'($urandom); group = 2'($urandom); pin = 3'($urandom);
        level = 1'($urandom); dirIn = 1'($urandom); busMan = 8'($urandom);
        repeat (3) begin @(posedge clk); #1; end
        for (int s = S_DRV; s <= S_STEP; s++) expect_at(cyc, s, 0);
        expect_at(cyc, S_LEDN, 0);
        mode = 0; group = 0; pin = 0; level = 0; dirIn = 0; busMan = 0;
        nreset = 1'b1;
        tr = cyc;
        expect_at(tr + 3, S_STEP, 0);
        expect_at(tr + 3, S_DRV, 0);
        wait_until(tr + 4);

        // Manual drive, then manual read high and low.
        apply(2'b00, 2'd1, 3'd5, 1'b1, 1'b0, t);
        expect_at(t + 2, S_DRV, 0);
        expect_at(t + 3, S_DRV, 32'h002000);
        expect_at(t + 3, S_OE, 32'h20);
        expect_at(t + 10, S_LEDN, 4);
        wait_until(t + 12);
        apply(2'b00, 2'd1, 3'd5, 1'b1, 1'b1, t);
        busMan = 8'h20;
        expect_at(t + 2, S_DRV, 32'h002000);
        expect_at(t + 3, S_DRV, 0);
        expect_at(t + 3, S_OE, 0);
        expect_at(t + 10, S_LEDN, 4);
        wait_until(t + 12);
        apply(2'b00, 2'd1, 3'd5, 1'b0, 1'b1, t);
        busMan = 8'h00;
        expect_at(t + 10, S_LEDN, 0);
        wait_until(t + 12);

        // Walk across all 24 pins and wrap.
        apply(2'b01, 2'd1, 3'd5, 1'b0, 1'b0, t);
        for (int k = 0; k <= 24; k++) begin
            j = k % 24;
            expect_at(t + 3 + 4 * k, S_DRV, 32'd1 << j);
            expect_at(t + 3 + 4 * k, S_STEP, j);
            expect_at(t + 3 + 4 * k, S_OE,
                      (j >= 8 && j < 16) ? (32'd1 << (j - 8)) : 32'd0);
        end
        expect_at(t + 6, S_DRV, 32'd1);
        wait_until(t + 3 + 96 + 2);

        // Toggle group 2 pin 0.
        apply(2'b10, 2'd2, 3'd0, 1'b0, 1'b0, t);
        for (int k = 0; k < 6; k++) begin
            expect_at(t + 3 + 4 * k, S_DRV, (k % 2 == 1) ? 32'h010000 : 32'd0);
            expect_at(t + 3 + 4 * k, S_OE, 0);
        end
        wait_until(t + 3 + 24);

        // Ideal loopback over 32 steps.
        busSel = 1;
        apply(2'b11, 2'd2, 3'd0, 1'b0, 1'b0, t);
        for (int k = 0; k <= 32; k++) begin
            j = k % 8;
            expect_at(t + 3 + 4 * k, S_DRV, (32'd1 << j) << 8);
            expect_at(t + 3 + 4 * k, S_STEP, j);
        end
        expect_at(t + 3, S_OE, 32'hFF);
        expect_at(t + 134, S_ERR, 0);
        expect_at(t + 134, S_CNT, 0);
        wait_until(t + 136);

        // Stuck bus bit 3: one mismatch per 8 steps, then leave at count 7.
        apply(2'b00, 2'd2, 3'd0, 1'b0, 1'b0, t);
        wait_until(t + 5);
        busSel = 2;
        apply(2'b11, 2'd2, 3'd0, 1'b0, 1'b0, t);
        expect_at(t + 17, S_ERR, 0);
        expect_at(t + 18, S_ERR, 1);
        for (int m = 0; m < 7; m++) begin
            expect_at(t + 18 + 32 * m, S_CNT, m + 1);
            if (m > 0) expect_at(t + 17 + 32 * m, S_CNT, m);
        end
        wait_until(t + 214);
        apply(2'b01, 2'd2, 3'd0, 1'b0, 1'b0, t2);
        expect_at(t2 + 2, S_CNT, 7);
        expect_at(t2 + 2, S_ERR, 1);
        expect_at(t2 + 3, S_CNT, 0);
        expect_at(t2 + 3, S_ERR, 0);
        expect_at(t2 + 3, S_STEP, 0);
        expect_at(t2 + 3, S_DRV, 1);
        wait_until(t2 + 8);

        // Saturation at 255.
        apply(2'b11, 2'd2, 3'd0, 1'b0, 1'b0, t);
        expect_at(t + 18 + 32 * 253, S_CNT, 254);
        expect_at(t + 17 + 32 * 254, S_CNT, 254);
        expect_at(t + 18 + 32 * 254, S_CNT, 255);
        expect_at(t + 18 + 32 * 255, S_CNT, 255);
        expect_at(t + 18 + 32 * 255, S_ERR, 1);
        wait_until(t + 18 + 32 * 255 + 2);

        // Asynchronous reset mid-step, then restart from step 0.
        @(posedge clk);
        #1;
        nreset = 1'b0;
        expect_at(cyc, S_ERR, 0);
        expect_at(cyc, S_CNT, 0);
        expect_at(cyc, S_DRV, 0);
        expect_at(cyc, S_OE, 0);
        expect_at(cyc, S_LED, 0);
        wait_until(cyc + 3);
        nreset = 1'b1;
        tr = cyc;
        expect_at(tr + 2, S_DRV, 0);
        expect_at(tr + 3, S_DRV, 32'h000100);
        expect_at(tr + 3, S_STEP, 0);
        expect_at(tr + 3, S_OE, 32'hFF);
        wait_until(tr + 6);

        t = cyc;
        while (q.size() != 0 && cyc < t + 20) begin
            @(posedge clk);
            #1;
        end
        if (q.size() != 0) begin
            nTests++;
            nFail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/expansion_pin_tester.md
# expansion_pin_tester

Parametrised board bring-up block for the expansion connectors. It drives any pin of `GROUPS` output groups of `PINS` pins each, with one group being the bidirectional data bus. Four modes are supported: manual drive/read, a walking-one sweep over every pin, a square-wave toggle on one pin, and a bus loopback check with a mismatch counter. It sits between the board switches and the connector pins and replaces the single-pin manual signal tester.

## Interface
- `PINS`, 8, pins per group (≥2)
- `GROUPS`, 3, number of output groups (≥2)
- `BUS_GROUP`, 1, index of the bidirectional bus group
- `DWELL_CYCLES`, 100000000, clock cycles per walk/toggle/loopback step (≥4)
- `PWM_BITS`, 3, LED PWM counter width (≥2)

- `i_clk100`  in  1  system clock
- `i_nreset`  in  1  reset, asynchronous, active-low
- `i_mode`  in  2  00 manual, 01 walk, 10 toggle, 11 loopback (asynchronous switches)
- `i_group`  in  clog2(GROUPS)  selected group (asynchronous)
- `i_pin`  in  clog2(PINS)  selected pin (asynchronous)
- `i_level`  in  1  manual drive level (asynchronous)
- `i_dirIn`  in  1  manual mode: 1 = read selected bus pin, 0 = drive (asynchronous)
- `i_busIn`  in  PINS  bus pin readback (asynchronous)
- `o_drive`  out  GROUPS*PINS  pin drive values; group g occupies bits [g*PINS +: PINS]
- `o_busOe`  out  PINS  per-pin output enable for `BUS_GROUP`
- `o_led`  out  1  PWM status LED
- `o_err`  out  1  sticky loopback mismatch flag
- `o_errCount`  out  8  loopback mismatch count, saturates at 255
- `o_step`  out  clog2(GROUPS*PINS)  current walk index / loopback step

## Operation
- All switch inputs and `i_busIn` pass through 2-flop synchronisers. The logic below uses only the synchronised values.
- A change of the synchronised mode clears the dwell counter, `o_step`, and the toggle level. It also clears `o_err` and `o_errCount`.
- Dwell counter: counts 0..DWELL_CYCLES-1 and then wraps. The wrap cycle is the "tick".
- **Manual (00):**
  - `i_dirIn`=0: only the selected pin equals `i_level`; every other `o_drive` bit is 0.
  - If the selected group is `BUS_GROUP`, only that pin's `o_busOe` bit is 1.
  - `i_dirIn`=1: `o_drive` is all 0 and `o_busOe` is 0. The LED reflects the synchronised `i_busIn[i_pin]`.
- **Walk (01):**
  - `o_drive` is one-hot at bit `o_step`.
  - `o_busOe` enables only the hot bus pin, if the hot bit lies in the bus group.
  - Each tick: `o_step` increments and wraps from GROUPS*PINS-1 to 0.
- **Toggle (10):**
  - The selected pin toggles each tick, starting at 0. All other pins are 0.
  - Bus OE follows the manual rule with direction = drive.
- **Loopback (11):**
  - The bus group drives the pattern `1 << (o_step mod PINS)` with `o_busOe` all 1. Other groups are 0.
  - Compare point: 3 cycles after each pattern change (synchroniser latency plus one), the synchronised `i_busIn` is compared with the driven pattern.
  - On mismatch: `o_err` is set and `o_errCount` increments, saturating at 255.
  - Each tick: `o_step` increments mod PINS.
- **LED:**
  - PWM counter free-runs. The duty window is `cnt < 2^(PWM_BITS-1)` (50%).
  - `o_led` = window AND source. Source is:
    - manual: the read level (`i_dirIn`=1) or `i_level`;
    - walk/toggle: the current drive level of the selected pin;
    - loopback: `o_err`.
- Out-of-range `i_group`/`i_pin` (values beyond GROUPS-1 or PINS-1) drive nothing and read 0.

## Timing
- All outputs are registered.
- Switch change to output change: 3 clocks (2 synchroniser + 1 output register).
- Reset values: `o_drive`=0, `o_busOe`=0, `o_led`=0, `o_err`=0, `o_errCount`=0, `o_step`=0. Dwell counter, PWM counter and toggle level are also 0.
- Reset asserted mid-step: all outputs go to their reset values immediately (asynchronous). After release, the mode restarts from step 0.
- Tick and mode change in the same cycle: the mode change wins and the step stays at 0.
- A mismatch on the compare cycle when `o_errCount`=255: the count holds and `o_err` stays 1.
- A step change occurring during the 3-cycle compare window suppresses that compare. This is not possible with DWELL_CYCLES≥4.

## Test plan
Benches run with DWELL_CYCLES=4, PINS=8, GROUPS=3, BUS_GROUP=1.

1. **Reset:** hold `i_nreset`=0 with random inputs → all outputs 0. Release → `o_step`=0.
2. **Manual drive:** mode 00, group 1, pin 5, level 1, `i_dirIn`=0 → 3 clocks later `o_drive`=24'h002000, `o_busOe`=8'h20. `o_led` pulses high 4 of 8 clocks.
3. **Walk:** mode 01 → `o_drive` bit 0 set, then a shift every 4 clocks. After bit 23, the next tick returns to bit 0 and `o_step`=0.
4. **Toggle:** mode 10, group 2, pin 0 → `o_drive[16]` toggles every 4 clocks, starting at 0. `o_busOe`=0.
5. **Loopback:**
   - With `i_busIn` tied to the driven bus pattern → `o_err`=0 after 32 steps.
   - With `i_busIn[3]` stuck at 0 → `o_err`=1 and `o_errCount` +1 per 8 steps. Counter saturates at 255.
6. **Mode change mid-count:** switch loopback→walk with `o_errCount`=7 → `o_errCount`=0, `o_err`=0, `o_step`=0 3 clocks later.
